// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: one-hot state codes,
// default pattern and a clog2 helper for counter sizing.
package seq_pkg;

  localparam logic [3:0] IdleCode  = 4'b0000;
  localparam logic [3:0] ShiftCode = 4'b0001;
  localparam logic [3:0] GapCode   = 4'b0010;
  localparam logic [3:0] DoneCode  = 4'b0100;

  typedef enum logic [3:0] {
    StIdle  = IdleCode,
    StShift = ShiftCode,
    StGap   = GapCode,
    StDone  = DoneCode
  } seq_state_e;

  localparam logic [3:0] SeqDefPat = 4'b1001;

  function automatic int unsigned seq_clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    v = 1;
    r = 0;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register; exposes the current MSB and the bit that
// becomes MSB after the next shift.
module seq_shift_reg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [PAT_W-1:0] din,
  output logic             msb,
  output logic             next_msb
);

  logic [PAT_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clear) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb      = sr_q[PAT_W-1];
  assign next_msb = sr_q[PAT_W-2];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends reps copies of a PAT_W-bit pattern MSB-first.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between consecutive copies.
module seq_generator
  import seq_pkg::*;
#(
  parameter int unsigned     PAT_W   = 4,
  parameter int unsigned     CNT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SeqDefPat)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             dataout,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitCntW = seq_clog2(PAT_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(PAT_W - 1);

  seq_state_e         state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   copy_cnt_q, copy_cnt_d;
  logic               dataout_q, dataout_d;
  logic               bit_valid_q, bit_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sr_load, sr_shift, sr_clear;
  logic [PAT_W-1:0]   sr_din;
  logic               sr_msb, sr_next_msb;

  seq_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sr_load),
    .shift    (sr_shift),
    .clear    (sr_clear),
    .din      (sr_din),
    .msb      (sr_msb),
    .next_msb (sr_next_msb)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    bit_cnt_d   = bit_cnt_q;
    copy_cnt_d  = copy_cnt_q;
    dataout_d   = 1'b0;
    bit_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_clear    = 1'b0;
    sr_din      = pat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d      = use_def ? DEF_PAT : pattern;
          copy_cnt_d = reps;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          if (reps != '0) begin
            state_d     = StShift;
            sr_load     = 1'b1;
            sr_din      = pat_d;
            dataout_d   = pat_d[PAT_W-1];
            bit_valid_d = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StShift: begin
        busy_d = 1'b1;
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d  = '0;
          copy_cnt_d = copy_cnt_q - CNT_W'(1);
          if (copy_cnt_q != CNT_W'(1)) begin
`ifdef SEQ_GEN_GAP_EN
            state_d = StGap;
`else
            sr_load     = 1'b1;
            sr_din      = pat_q;
            dataout_d   = pat_q[PAT_W-1];
            bit_valid_d = 1'b1;
`endif
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          sr_shift    = 1'b1;
          dataout_d   = sr_next_msb;
          bit_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + BitCntW'(1);
        end
      end

`ifdef SEQ_GEN_GAP_EN
      StGap: begin
        state_d     = StShift;
        busy_d      = 1'b1;
        sr_load     = 1'b1;
        sr_din      = pat_q;
        dataout_d   = pat_q[PAT_W-1];
        bit_valid_d = 1'b1;
      end
`endif

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // abort wins over every transition out of a busy state
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      bit_cnt_d   = '0;
      copy_cnt_d  = '0;
      dataout_d   = 1'b0;
      bit_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_clear    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      copy_cnt_q  <= '0;
      dataout_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      copy_cnt_q  <= copy_cnt_d;
      dataout_q   <= dataout_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // While shifting, the registered output always mirrors the register MSB.
  shift_tracks_msb: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StShift) |-> (dataout_q == sr_msb));

  assign dataout   = dataout_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed self-checking bench for seq_generator; outputs sampled 1 time unit after
// each rising edge, inputs driven at the same point.
module tb_seq_generator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       use_def;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       abort;
  logic       dataout;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  seq_generator #(
    .PAT_W (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .use_def   (use_def),
    .pattern   (pattern),
    .reps      (reps),
    .abort     (abort),
    .dataout   (dataout),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sample edge; returns positioned in cycle 1.
  task automatic launch(input logic def, input logic [3:0] pat, input logic [3:0] n);
    start   = 1'b1;
    use_def = def;
    pattern = pat;
    reps    = n;
    tick();
    start   = 1'b0;
    use_def = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_bits;
    exp_bits = 4'b1001;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
    rst_n = 1'b1;
    tick();
    launch(1'b0, 4'b1111, 4'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_mid_shift: got %b expected 0000",
               {dataout, bit_valid, busy, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    launch(1'b1, 4'b0110, 4'd1);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== {exp_bits[3-c], 3'b110}) begin
        n_fail++;
        $display("FAIL def_pat_bit%0d: got %b expected %b", c,
                 {dataout, bit_valid, busy, done}, {exp_bits[3-c], 3'b110});
      end
      tick();
    end
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL def_pat_done: got %b expected 0011", {dataout, bit_valid, busy, done});
    end
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL def_pat_idle: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask

`ifndef SEQ_GEN_GAP_EN
  task automatic test_reps3();
    logic [3:0] pat;
    pat = 4'b1101;
    launch(1'b0, pat, 4'd3);
    for (int c = 1; c <= 12; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== {pat[3-((c-1)%4)], 3'b110}) begin
        n_fail++;
        $display("FAIL reps3_cycle%0d: got %b expected %b", c,
                 {dataout, bit_valid, busy, done}, {pat[3-((c-1)%4)], 3'b110});
      end
      if (c == 5) begin
        start   = 1'b1;
        use_def = 1'b1;
      end
      if (c == 6) begin
        start   = 1'b0;
        use_def = 1'b0;
      end
      tick();
    end
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reps3_done: got %b expected 0011", {dataout, bit_valid, busy, done});
    end
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reps3_idle: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask
`else
  task automatic test_gap();
    logic [8:0] seq_bits;
    logic [8:0] seq_vld;
    seq_bits = 9'b100101001;
    seq_vld  = 9'b111101111;
    launch(1'b0, 4'b1001, 4'd2);
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== {seq_bits[8-c], seq_vld[8-c], 2'b10}) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: got %b expected %b", c + 1,
                 {dataout, bit_valid, busy, done}, {seq_bits[8-c], seq_vld[8-c], 2'b10});
      end
      tick();
    end
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL gap_done: got %b expected 0011", {dataout, bit_valid, busy, done});
    end
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL gap_idle: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask
`endif

  task automatic test_zero_reps();
    launch(1'b0, 4'b1010, 4'd0);
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL zero_reps_done: got %b expected 0011", {dataout, bit_valid, busy, done});
    end
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_reps_idle: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp_v [0:3];
    // first copy of 4'b1011: cycles 1..3 seen before the abort
    exp_v[0] = 4'b1110;
    exp_v[1] = 4'b0110;
    exp_v[2] = 4'b1110;
    launch(1'b0, 4'b1011, 4'd2);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== exp_v[c]) begin
        n_fail++;
        $display("FAIL abort_pre_cycle%0d: got %b expected %b", c + 1,
                 {dataout, bit_valid, busy, done}, exp_v[c]);
      end
      if (c == 2) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL abort_idle_cycle%0d: got %b expected 0000", c,
                 {dataout, bit_valid, busy, done});
      end
      if (c == 5) begin
        start   = 1'b1;
        pattern = 4'b1010;
        reps    = 4'd1;
      end
      tick();
    end
    start = 1'b0;
    exp_v[0] = 4'b1110;
    exp_v[1] = 4'b0110;
    exp_v[2] = 4'b1110;
    exp_v[3] = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== exp_v[c]) begin
        n_fail++;
        $display("FAIL restart_cycle%0d: got %b expected %b", c + 6,
                 {dataout, bit_valid, busy, done}, exp_v[c]);
      end
      tick();
    end
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0011) begin
      n_fail++;
      $display("FAIL restart_done: got %b expected 0011", {dataout, bit_valid, busy, done});
    end
    tick();
    // abort is ignored in IDLE, so start still launches
    abort   = 1'b1;
    start   = 1'b1;
    pattern = 4'b1000;
    reps    = 4'd1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b1110) begin
      n_fail++;
      $display("FAIL abort_in_idle: got %b expected 1110", {dataout, bit_valid, busy, done});
    end
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_last_bit_no_done: got %b expected 0000",
               {dataout, bit_valid, busy, done});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [3:0] exp;
    int p;
    pat     = 4'b1100;
    start   = 1'b1;
    use_def = 1'b0;
    pattern = pat;
    reps    = 4'd1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      p = (c - 1) % 6;
      if (p < 4)       exp = {pat[3-p], 3'b110};
      else if (p == 4) exp = 4'b0011;
      else             exp = 4'b0000;
      n_checks++;
      if ({dataout, bit_valid, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", c,
                 {dataout, bit_valid, busy, done}, exp);
      end
      if (c == 18) start = 1'b0;
      tick();
    end
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_stop: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask

  task automatic test_max_reps();
    int cyc;
    int nbits;
`ifdef SEQ_GEN_GAP_EN
    int done_cyc = 75;
`else
    int done_cyc = 61;
`endif
    cyc   = 1;
    nbits = 0;
    launch(1'b0, 4'b1011, 4'd15);
    while (done !== 1'b1 && cyc < 200) begin
      if (bit_valid === 1'b1) nbits++;
      tick();
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL max_reps_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
    n_checks++;
    if (nbits != 60) begin
      n_fail++;
      $display("FAIL max_reps_bits: got %0d valid bits expected 60", nbits);
    end
    n_checks++;
    if (cyc != done_cyc) begin
      n_fail++;
      $display("FAIL max_reps_done_cycle: got %0d expected %0d", cyc, done_cyc);
    end
    tick();
    n_checks++;
    if ({dataout, bit_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL max_reps_idle: got %b expected 0000", {dataout, bit_valid, busy, done});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    use_def  = 1'b0;
    pattern  = 4'b0000;
    reps     = 4'd0;
    abort    = 1'b0;
    test_reset();
`ifndef SEQ_GEN_GAP_EN
    test_reps3();
`else
    test_gap();
`endif
    test_zero_reps();
    test_abort();
    test_back_to_back();
    test_max_reps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
- Serial pattern transmitter: loads a PAT_W-bit pattern and repeat count on start, then shifts the pattern out MSB-first on one serial line, one bit per clock, for the requested number of copies.
- Drives the serial datain of the team's serial pattern detectors; used as bench stimulus and as an on-chip test-pattern source.

Parameters:
- PAT_W, 4, pattern width in bits (>=2)
- CNT_W, 4, repeat-count width
- DEF_PAT, 4'b1001, pattern substituted when use_def=1

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- use_def  input  1  at start: 1 = send DEF_PAT, 0 = send pattern
- pattern  input  PAT_W  pattern captured at start
- reps  input  CNT_W  number of copies to send (0 = none)
- abort  input  1  synchronous abandon of current transfer
- dataout  output  1  serial bit, registered
- bit_valid  output  1  dataout carries a pattern bit this cycle
- busy  output  1  transfer in progress
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE, dataout=0, bit_valid=0, busy=0, done=0, shift register and counters cleared. First active edge after deassertion behaves as IDLE.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, SHIFT, GAP (macro only), DONE.
- IDLE: dataout=0, bit_valid=0, busy=0. On start=1, capture the pattern (DEF_PAT if use_def, else pattern) and reps.
  - reps!=0: go to SHIFT.
  - reps==0: go to DONE.
- SHIFT: each cycle dataout=current MSB, bit_valid=1, busy=1; register shifts left, bit counter increments.
  - First bit appears on the cycle after start is sampled (latency 1).
  - After bit PAT_W-1 (LSB), the copy counter decrements.
  - If copies remain, the next cycle emits the MSB of a freshly reloaded copy, back-to-back with no gap (GAP state under macro).
  - After the last copy, go to DONE.
- DONE: exactly one cycle; done=1, busy=1, bit_valid=0, dataout=0. Then IDLE.
- start is ignored while busy (SHIFT/GAP/DONE). start in the DONE cycle is dropped. start in the first IDLE cycle after DONE is accepted.
- abort=1 in SHIFT/GAP/DONE: next cycle is IDLE with all outputs 0 and no done pulse. abort has priority over start and over all transitions; it has no effect in IDLE.
- Counter widths: bit counter is clog2(PAT_W) bits and wraps 0 after PAT_W-1. The copy counter never underflows; reps=2^CNT_W-1 sends that many copies.
- Bits sent per transfer = reps*PAT_W (plus reps-1 gap bits under macro). done fires the cycle after the last bit.

Optional Feature:
- Macro SEQ_GEN_GAP_EN.
- Defined: between consecutive copies the block spends one GAP cycle with dataout=0, bit_valid=0, busy=1. No GAP after the last copy. abort is honoured in GAP.
- Undefined: GAP state and logic are absent; copies are emitted back-to-back.

Decomposition:
- Package seq_pkg: state encoding localparams (one-hot, 4 bits: IDLE=0000, SHIFT=0001, GAP=0010, DONE=0100), default pattern constant, clog2 helper function.
- Sub-module seq_shift_reg: PAT_W-bit loadable left-shift register with load, shift and clear controls and an MSB output. The FSM and both counters stay in seq_generator.

Test Plan:
- Reset mid-SHIFT: assert rst_n=0 asynchronously on bit 2 -> outputs 0 immediately; after release, start with use_def=1, reps=1 -> dataout 1,0,0,1 on cycles 1-4 with bit_valid=1, done=1 on cycle 5, busy low on cycle 6.
- pattern=4'b1101, reps=3, macro off -> 12 contiguous valid bits 110111011101, single done pulse on cycle 13; start pulsed on cycle 5 has no effect.
- reps=0 -> no bit_valid, done=1 on cycle 1, busy=1 only on cycle 1.
- abort on cycle 3 of a reps=2 transfer -> IDLE on cycle 4, done never asserts; a new start on cycle 5 gives first bit on cycle 6.
- Macro on, pattern=4'b1001, reps=2 -> dataout 1001,0(gap, bit_valid=0),1001, done on cycle 10.
- Back-to-back: start held high continuously, reps=1 -> transfers restart on the first IDLE cycle after each DONE, period PAT_W+2 cycles, never overlapping.
